// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with combinational head data and not-empty flag.
// Optional sticky overflow/underflow flags under SYNC_FIFO_ERR_EN.
module sync_fifo #(
  parameter int DATAWIDTH   = 8,
  parameter int ADDRWIDTH   = 4,
  parameter int AFULL_LEVEL = 2**ADDRWIDTH-2
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic [DATAWIDTH-1:0] wr_data,
  input  logic                 we,
  input  logic                 re,
  output logic [DATAWIDTH-1:0] ns_rd_data,
  output logic                 ns_ne,
  output logic                 full,
  output logic                 afull,
  output logic [ADDRWIDTH:0]   level
`ifdef SYNC_FIFO_ERR_EN
  ,
  output logic                 ovf,
  output logic                 udf
`endif
);

  localparam int DEPTH = 2**ADDRWIDTH;
  localparam logic [ADDRWIDTH:0] DEPTH_L = {1'b1, {ADDRWIDTH{1'b0}}};
  localparam logic [31:0] AF32 = AFULL_LEVEL;
  localparam logic [ADDRWIDTH:0] AF_L = AF32[ADDRWIDTH:0];

  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic [ADDRWIDTH-1:0] wp;
  logic [ADDRWIDTH-1:0] rp;
  logic                 pop;
  logic                 push;

  assign ns_ne      = (level != '0);
  assign full       = (level == DEPTH_L);
  assign afull      = (level >= AF_L);
  assign ns_rd_data = mem[rp];

  // A pop frees a slot in the same edge, so a push at full is legal with it.
  assign pop  = re & ns_ne;
  assign push = we & (~full | pop);

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (we & full & ~pop) ovf <= 1'b1;
      if (re & ~ns_ne)      udf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       reset_l;
  logic [7:0] wr_data;
  logic       we;
  logic       re;
  logic [7:0] ns_rd_data;
  logic       ns_ne;
  logic       full;
  logic       afull;
  logic [4:0] level;
`ifdef SYNC_FIFO_ERR_EN
  logic       ovf;
  logic       udf;
`endif

  always #5 clk = ~clk;

  sync_fifo dut (
    .clk        (clk),
    .reset_l    (reset_l),
    .wr_data    (wr_data),
    .we         (we),
    .re         (re),
    .ns_rd_data (ns_rd_data),
    .ns_ne      (ns_ne),
    .full       (full),
    .afull      (afull),
    .level      (level)
`ifdef SYNC_FIFO_ERR_EN
    ,
    .ovf        (ovf),
    .udf        (udf)
`endif
  );

  logic [7:0] q[$];
  logic [7:0] popped[$];
  logic [7:0] expq[$];
  bit         m_ovf;
  bit         m_udf;
  bit         ne_reg;
  int         errors = 0;
  int         checks = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("level", 32'(level), q.size());
    chk("ns_ne", 32'(ns_ne), 32'(q.size() != 0));
    chk("full",  32'(full),  32'(q.size() == 16));
    chk("afull", 32'(afull), 32'(q.size() >= 14));
    if (q.size() != 0) chk("head", 32'(ns_rd_data), 32'(q[0]));
`ifdef SYNC_FIFO_ERR_EN
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("udf", 32'(udf), 32'(m_udf));
`endif
  endtask

  task automatic step(bit w, bit r, logic [7:0] d);
    bit pop_ok;
    bit push_ok;
    we      = w;
    re      = r;
    wr_data = d;
    pop_ok  = r && q.size() != 0;
    push_ok = w && (q.size() < 16 || pop_ok);
    if (r && q.size() == 0) m_udf = 1'b1;
    if (w && q.size() == 16 && !pop_ok) m_ovf = 1'b1;
    if (pop_ok) begin
      chk("pop_data", 32'(ns_rd_data), 32'(q[0]));
      popped.push_back(q[0]);
    end
    @(posedge clk);
    if (pop_ok) void'(q.pop_front());
    if (push_ok) q.push_back(d);
    #1;
    check_state();
  endtask

  task automatic cmp_popped(string tag);
    chk({tag, "_count"}, popped.size(), expq.size());
    for (int i = 0; i < expq.size() && i < popped.size(); i++)
      chk(tag, 32'(popped[i]), 32'(expq[i]));
    popped.delete();
    expq.delete();
  endtask

  // Producer writes 1..n; consumer's re is a registered copy of ns_ne.
  task automatic burst(int n);
    bit ne_now;
    ne_reg = 1'b0;
    for (int i = 1; i <= n; i++) begin
      ne_now = q.size() != 0;
      step(1'b1, ne_reg, 8'(i));
      ne_reg = ne_now;
      expq.push_back(8'(i));
    end
    for (int k = 0; k < 20 && (q.size() != 0 || ne_reg); k++) begin
      ne_now = q.size() != 0;
      step(1'b0, ne_reg, 8'h00);
      ne_reg = ne_now;
    end
    chk("burst_drained", q.size(), 0);
  endtask

  task automatic do_reset();
    reset_l = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    #1;
    check_state();
    chk("rst_level0", 32'(level), 0);
    #2 reset_l = 1'b1;
  endtask

  initial begin
    reset_l = 1'b0;
    we      = 1'b0;
    re      = 1'b0;
    wr_data = '0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    #12;
    check_state();
    #2 reset_l = 1'b1;
    @(posedge clk); #1;
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    // Asynchronous reset mid-cycle with data in flight
    step(1'b1, 1'b0, 8'hA1);
    step(1'b1, 1'b0, 8'hA2);
    step(1'b1, 1'b0, 8'hA3);
    #2;
    do_reset();
    step(1'b0, 1'b0, 8'h00);

    burst(6);
    cmp_popped("burst6");
    repeat (10) step(1'b0, 1'b0, 8'h00);
    burst(4);
    cmp_popped("burst4");

    // Fill, overflow attempt, full push+pop, drain
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
    step(1'b1, 1'b0, 8'hAA);
    popped.delete();
    step(1'b1, 1'b1, 8'h55);
    chk("full_pp_head", 32'(ns_rd_data), 32'h11);
    for (int k = 0; k < 20 && q.size() != 0; k++) step(1'b0, 1'b1, 8'h00);
    expq.push_back(8'h10);
    for (int i = 1; i < 16; i++) expq.push_back(8'(8'h10 + i));
    expq.push_back(8'h55);
    cmp_popped("fill_drain");

    // Empty push+pop: only the push lands, no bypass
    step(1'b1, 1'b1, 8'h7E);
    chk("empty_pp_head", 32'(ns_rd_data), 32'h7E);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 8'($urandom));

    // Random traffic alternating fill-biased and drain-biased phases
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 50; i++) begin
        if (p[0])
          step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, 8'($urandom));
        else
          step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 8'($urandom));
      end
    end

    #2;
    do_reset();
    step(1'b0, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim did not finish");
    $fatal(1, "timeout");
  end

endmodule
